// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types, widths and helpers for the memory bus arbiter
// Purpose: FSM state encoding, default bus widths and index-width helper.
// Ports: none (package).
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  localparam int WORD_SIZE = 16;
  localparam int ADDR_SIZE = 8;

  // Width needed to hold an index 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// rtl/mem_bus_arbiter_rr_picker.sv - combinational round-robin winner picker
// Purpose: pick the first set request scanning upward from last_gnt+1 (mod NREQ).
// Ports:
//   i_req      in  NREQ  request vector
//   i_last_gnt in  IW    index of the previous winner
//   o_winner   out IW    index of the new winner (valid only with o_valid)
//   o_valid    out 1     at least one request present
module mem_bus_arbiter_rr_picker
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last_gnt,
  output logic [IW-1:0]   o_winner,
  output logic            o_valid
);

  logic [NREQ-1:0] w_rot;
  int unsigned     w_start;
  int unsigned     w_pos;

  // Rotate so that bit 0 is the master after the last winner, priority-encode
  // the lowest set bit, then rotate the found position back to a real index.
  always_comb begin
    w_start = (int'(i_last_gnt) + 1) % NREQ;
    w_rot   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_rot[i] = i_req[(w_start + i) % NREQ];
    end
    w_pos = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pos = i;
    end
    o_valid  = |i_req;
    o_winner = IW'((w_pos + w_start) % NREQ);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one single-port memory among NREQ masters
// Purpose: request/grant handshake, IDLE -> GRANT -> RELEASE turnaround, muxes the owner onto memory.
// Optional feature macro: ARB_HOLD_LIMIT_EN (preempt an owner after MAX_HOLD grant cycles when others wait).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req/req_we [NREQ]        per-master request and write enable
//   req_addr  [NREQ*AW]      flattened addresses, master i at [i*AW +: AW]
//   req_wdata [NREQ*DW]      flattened write data, master i at [i*DW +: DW]
//   gnt       [NREQ]         registered one-hot (or zero) grant
//   rdata     [DW]           memory read data broadcast
//   mem_addr/mem_wdata/mem_we  memory-side request, mem_rdata memory read data
//   busy                     arbiter not idle
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int DW       = WORD_SIZE,
  parameter int AW       = ADDR_SIZE,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ-1:0]    req_we,
  output logic [NREQ-1:0]    gnt,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic               mem_we,
  input  logic [DW-1:0]      mem_rdata,
  output logic               busy
);

  localparam int IW = idx_width(NREQ);
  localparam int HW = idx_width(MAX_HOLD + 1);

`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HOLD_LIMIT = 1'b1;
`else
  localparam bit HOLD_LIMIT = 1'b0;
`endif

  arb_state_e      r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [IW-1:0]   r_gnt_idx, w_gnt_idx_nxt;
  logic [IW-1:0]   r_last_gnt, w_last_gnt_nxt;
  logic [HW-1:0]   r_hold_cnt, w_hold_cnt_nxt;
  logic [AW-1:0]   r_addr_hold;
  logic [DW-1:0]   r_wdata_hold;

  logic [AW-1:0]   w_addr_arr  [NREQ];
  logic [DW-1:0]   w_wdata_arr [NREQ];
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic            w_sel_req;
  logic            w_sel_we;
  logic            w_others;
  logic            w_preempt;
  logic [IW-1:0]   w_winner;
  logic            w_valid;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_addr_arr[i]  = req_addr[i*AW +: AW];
    assign w_wdata_arr[i] = req_wdata[i*DW +: DW];
  end

  mem_bus_arbiter_rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .i_req      (req),
    .i_last_gnt (r_last_gnt),
    .o_winner   (w_winner),
    .o_valid    (w_valid)
  );

  assign w_sel_addr  = w_addr_arr[r_gnt_idx];
  assign w_sel_wdata = w_wdata_arr[r_gnt_idx];
  assign w_sel_req   = req[r_gnt_idx];
  assign w_sel_we    = req_we[r_gnt_idx];
  assign w_others    = |(req & ~r_gnt);

  // With the hold limit compiled out HOLD_LIMIT is constant zero and the
  // hold counter has no effect on behaviour.
  assign w_preempt = HOLD_LIMIT && (r_hold_cnt == HW'(MAX_HOLD - 1)) && w_others;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_gnt        <= '0;
      r_gnt_idx    <= '0;
      r_last_gnt   <= IW'(NREQ - 1);
      r_hold_cnt   <= '0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_idx  <= w_gnt_idx_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      // Capture the owner's bus so RELEASE/IDLE keep presenting the last value.
      if (r_state == ARB_GRANT) begin
        r_addr_hold  <= w_sel_addr;
        r_wdata_hold <= w_sel_wdata;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_idx_nxt  = r_gnt_idx;
    w_last_gnt_nxt = r_last_gnt;
    w_hold_cnt_nxt = r_hold_cnt;
    mem_addr       = r_addr_hold;
    mem_wdata      = r_wdata_hold;
    mem_we         = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        if (w_valid) begin
          w_state_nxt    = ARB_GRANT;
          w_gnt_nxt      = '0;
          w_gnt_nxt[w_winner] = 1'b1;
          w_gnt_idx_nxt  = w_winner;
          w_last_gnt_nxt = w_winner;
          w_hold_cnt_nxt = '0;
        end
      end
      ARB_GRANT: begin
        mem_addr  = w_sel_addr;
        mem_wdata = w_sel_wdata;
        // A write coinciding with the owner dropping req is blocked.
        mem_we    = w_sel_req & w_sel_we;
        if (r_hold_cnt != '1) w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        if (!w_sel_req || w_preempt) begin
          w_state_nxt = ARB_RELEASE;
          w_gnt_nxt   = '0;
        end
      end
      ARB_RELEASE: begin
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  assign gnt   = r_gnt;
  assign busy  = (r_state != ARB_IDLE);
  assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter (NREQ=2 and NREQ=4)
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic [1:0]  req, req_we, gnt;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  logic        mem_we, busy;

  logic [3:0]  req4, req_we4, gnt4;
  logic [31:0] req_addr4;
  logic [63:0] req_wdata4;
  logic [15:0] rdata4, mem_wdata4, mem_rdata4;
  logic [7:0]  mem_addr4;
  logic        mem_we4, busy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NREQ(2), .DW(16), .AW(8), .MAX_HOLD(8)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_we(req_we), .gnt(gnt), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_bus_arbiter #(.NREQ(4), .DW(16), .AW(8), .MAX_HOLD(8)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .req_addr(req_addr4), .req_wdata(req_wdata4),
    .req_we(req_we4), .gnt(gnt4), .rdata(rdata4), .mem_addr(mem_addr4),
    .mem_wdata(mem_wdata4), .mem_we(mem_we4), .mem_rdata(mem_rdata4), .busy(busy4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; mem_rdata = '0;
    req4 = '0; req_we4 = '0; req_wdata4 = '0; mem_rdata4 = '0;
    req_addr4 = {8'h43, 8'h42, 8'h41, 8'h40};
    step(); step();
    rst = 1'b0;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin
      errors++; $display("FAIL reset_mem_bus got %h/%h want 00/0000", mem_addr, mem_wdata); end
    checks++; if (gnt4 !== 4'b0000 || busy4 !== 1'b0) begin
      errors++; $display("FAIL reset4 got gnt %b busy %b want 0000 0", gnt4, busy4); end
  endtask

  task automatic test_grant_write();
    req_addr  = {8'h20, 8'h10};
    req_wdata = {16'h1234, 16'hBEEF};
    req_we    = 2'b11;
    req       = 2'b11;
    mem_rdata = 16'h5A5A;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ungranted_we got %b want 0", mem_we); end
    checks++; if (rdata !== 16'h5A5A) begin errors++; $display("FAIL rdata_bcast got %h want 5a5a", rdata); end
    step();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL first_gnt got %b want 01", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL grant_busy got %b want 1", busy); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 16'hBEEF) begin
      errors++; $display("FAIL m0_write got we %b %h/%h want 1 10/beef", mem_we, mem_addr, mem_wdata); end
    req_addr[7:0] = 8'h11;
    #1;
    checks++; if (mem_addr !== 8'h11) begin errors++; $display("FAIL addr_track got %h want 11", mem_addr); end
  endtask

  task automatic test_release_handover();
    req[0] = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL drop_write_blocked got %b want 0", mem_we); end
    step();
    checks++; if (gnt !== 2'b00 || mem_we !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL release got gnt %b we %b busy %b want 00 0 1", gnt, mem_we, busy); end
    checks++; if (mem_addr !== 8'h11) begin errors++; $display("FAIL release_hold_addr got %h want 11", mem_addr); end
    step();
    checks++; if (gnt !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_turnaround got gnt %b busy %b want 00 0", gnt, busy); end
    step();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL m1_gnt got %b want 10", gnt); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 16'h1234) begin
      errors++; $display("FAIL m1_write got we %b %h/%h want 1 20/1234", mem_we, mem_addr, mem_wdata); end
  endtask

  task automatic test_reset_mid_grant();
    req = 2'b10;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (gnt !== 2'b00 || mem_we !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset got gnt %b we %b busy %b want 00 0 0", gnt, mem_we, busy); end
    req = 2'b11;
    step();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL post_reset_gnt got %b want 01", gnt); end
  endtask

  task automatic test_hold();
    logic [1:0] exp;
    for (int k = 1; k < 18; k++) begin
      step();
`ifdef ARB_HOLD_LIMIT_EN
      exp = (k < 8) ? 2'b01 : ((k < 10) ? 2'b00 : 2'b10);
`else
      exp = 2'b01;
`endif
      checks++; if (gnt !== exp) begin
        errors++; $display("FAIL hold_cycle%0d got %b want %b", k, gnt, exp); end
    end
    req = 2'b00;
    step(); step(); step();
  endtask

  task automatic wait_gnt4(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (gnt4 !== 4'b0000) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL gnt4_timeout got %b want nonzero", gnt4);
    end
  endtask

  task automatic test_rotation4();
    bit ok;
    int order [4] = '{3, 0, 1, 2};
    logic [3:0] exp;
    mem_rdata4 = 16'hC3C3;
    req4 = 4'b0100;
    wait_gnt4(ok);
    checks++; if (gnt4 !== 4'b0100) begin errors++; $display("FAIL set_last2 got %b want 0100", gnt4); end
    checks++; if (rdata4 !== 16'hC3C3) begin errors++; $display("FAIL rdata4 got %h want c3c3", rdata4); end
    req4 = 4'b0000;
    step(); step();
    req4 = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      wait_gnt4(ok);
      exp = 4'b0001 << order[j];
      checks++; if (gnt4 !== exp) begin
        errors++; $display("FAIL rot_order%0d got %b want %b", j, gnt4, exp); end
      checks++; if (mem_addr4 !== 8'(8'h40 + order[j])) begin
        errors++; $display("FAIL rot_addr%0d got %h want %h", j, mem_addr4, 8'(8'h40 + order[j])); end
      req4[order[j]] = 1'b0;
    end
    req4 = 4'b0100;
    for (int r = 0; r < 3; r++) begin
      wait_gnt4(ok);
      checks++; if (gnt4 !== 4'b0100) begin
        errors++; $display("FAIL lone_regrant%0d got %b want 0100", r, gnt4); end
      req4 = 4'b0000;
      step();
      req4 = 4'b0100;
    end
    req4 = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_grant_write();
    test_release_handover();
    test_reset_mid_grant();
    test_hold();
    test_rotation4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
